// File: rtl/dot_accum.sv
// Signed dot-product accumulator: sums LEN 6-bit products into a saturating
// ACC_W-bit result and hands it off on a valid/ready output with an overflow flag.
module dot_accum #(
  parameter int LEN   = 8,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic [7:0]       frame_cnt
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;

  logic [ACC_W:0]     sum;
  logic               ovf_now;
  logic [ACC_W-1:0]   sum_sat;
  logic               xfer;

  assign in_ready = (state_q == ACCUM) || out_ready;
  assign xfer     = in_valid && in_ready && !clear;

  // One guard bit is enough: |prod| is far below the accumulator range.
  always_comb begin
    sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-5){prod[5]}}, prod};
    ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
    sum_sat = sum[ACC_W-1:0];
    if (ovf_now) sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  // In HOLD acc/cnt are already zero, so a handoff-cycle transfer starts a new frame.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    if (clear) begin
      acc_d       = '0;
      cnt_d       = '0;
      sticky_d    = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end else begin
      if (state_q == HOLD && out_ready) begin
        out_valid_d = 1'b0;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = ACCUM;
      end
      if (xfer) begin
        if (cnt_q == LAST) begin
          result_d    = sum_sat;
          ovf_d       = sticky_q | ovf_now;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          sticky_d    = 1'b0;
          state_d     = HOLD;
        end else begin
          acc_d    = sum_sat;
          cnt_d    = cnt_q + CNT_W'(1);
          sticky_d = sticky_q | ovf_now;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign frame_cnt = frame_cnt_q;

endmodule
